// File: rtl/hilo_mdu_controller.sv
// HI/LO write sequencer: single-cycle MULT/MULTU and MTHI/MTLO, plus a
// 32-iteration restoring divider that stalls the pipeline while it runs.
module hilo_mdu_controller #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        annul,
  output logic        stall_request,
  output logic        busy,
  output logic        register_hi_write_enable,
  output logic [31:0] register_hi_write_data,
  output logic        register_lo_write_enable,
  output logic [31:0] register_lo_write_data
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, DIV_RUN} state_t;

  state_t      state_q;
  logic [4:0]  count_q;
  logic [31:0] rem_q, quot_q, divisor_q, dividend_q;
  logic        neg_quot_q, neg_rem_q, div_zero_q;
  logic        hi_we_q, lo_we_q;
  logic [31:0] hi_data_q, lo_data_q;

  // Handshake: an op is taken on a posedge when op_valid=1, annul=0 and the
  // unit is IDLE; there is no ready, the pipeline holds via stall_request.
  logic accept, is_div;
  assign accept = op_valid & ~annul & (state_q == IDLE);
  assign is_div = (op_code == OP_DIV) | (op_code == OP_DIVU);

  assign busy          = (state_q == DIV_RUN);
  assign stall_request = busy | (accept & is_div);

  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
  assign prod_u = {32'd0, operand_a} * {32'd0, operand_b};

  // Signed divide runs on magnitudes; signs are reapplied to the final result.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = (op_code == OP_DIV) & operand_a[31];
  assign b_neg = (op_code == OP_DIV) & operand_b[31];
  assign a_mag = a_neg ? (~operand_a + 32'd1) : operand_a;
  assign b_mag = b_neg ? (~operand_b + 32'd1) : operand_b;

  logic [32:0] shifted, diff;
  logic        step_ok;
  logic [31:0] rem_step, quot_step, rem_res, quot_res;
  assign shifted   = {rem_q, quot_q[31]};
  assign diff      = shifted - {1'b0, divisor_q};
  assign step_ok   = ~diff[32];
  assign rem_step  = step_ok ? diff[31:0] : shifted[31:0];
  assign quot_step = {quot_q[30:0], step_ok};
  assign quot_res  = neg_quot_q ? (~quot_step + 32'd1) : quot_step;
  assign rem_res   = neg_rem_q ? (~rem_step + 32'd1) : rem_step;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      rem_q      <= 32'd0;
      quot_q     <= 32'd0;
      divisor_q  <= 32'd0;
      dividend_q <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_we_q    <= 1'b0;
      lo_we_q    <= 1'b0;
      hi_data_q  <= 32'd0;
      lo_data_q  <= 32'd0;
    end else begin
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op_code)
              OP_MULT: begin
                hi_we_q   <= 1'b1;
                lo_we_q   <= 1'b1;
                hi_data_q <= prod_s[63:32];
                lo_data_q <= prod_s[31:0];
              end
              OP_MULTU: begin
                hi_we_q   <= 1'b1;
                lo_we_q   <= 1'b1;
                hi_data_q <= prod_u[63:32];
                lo_data_q <= prod_u[31:0];
              end
              OP_MTHI: begin
                hi_we_q   <= 1'b1;
                hi_data_q <= operand_a;
              end
              OP_MTLO: begin
                lo_we_q   <= 1'b1;
                lo_data_q <= operand_a;
              end
              OP_DIV, OP_DIVU: begin
                state_q    <= DIV_RUN;
                count_q    <= 5'd0;
                rem_q      <= 32'd0;
                quot_q     <= a_mag;
                divisor_q  <= b_mag;
                dividend_q <= operand_a;
                neg_quot_q <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (operand_b == 32'd0);
              end
              default: ;
            endcase
          end
        end
        DIV_RUN: begin
          if (annul) begin
            state_q <= IDLE;
            count_q <= 5'd0;
          end else begin
            rem_q   <= rem_step;
            quot_q  <= quot_step;
            count_q <= count_q + 5'd1;
            if (count_q == LAST_ITER) begin
              state_q   <= IDLE;
              count_q   <= 5'd0;
              hi_we_q   <= 1'b1;
              lo_we_q   <= 1'b1;
              // Divide by zero still runs all iterations, then reports fixed values.
              lo_data_q <= div_zero_q ? 32'hFFFF_FFFF : quot_res;
              hi_data_q <= div_zero_q ? dividend_q : rem_res;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign register_hi_write_enable = hi_we_q;
  assign register_lo_write_enable = lo_we_q;
  assign register_hi_write_data   = hi_data_q;
  assign register_lo_write_data   = lo_data_q;

endmodule

// File: tb/tb_hilo_mdu_controller.sv
// Directed + light random bench for hilo_mdu_controller: expected HI/LO
// writes are queued with their due cycle and matched by a write monitor.
`timescale 1ns/1ps
module tb_hilo_mdu_controller;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        annul = 1'b0;
  logic        stall_request, busy;
  logic        hi_we, lo_we;
  logic [31:0] hi_data, lo_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [65:0] exp_q[$];
  int          due_q[$];

  hilo_mdu_controller #(.DIV_CYCLES(32)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .op_valid                 (op_valid),
    .op_code                  (op_code),
    .operand_a                (operand_a),
    .operand_b                (operand_b),
    .annul                    (annul),
    .stall_request            (stall_request),
    .busy                     (busy),
    .register_hi_write_enable (hi_we),
    .register_hi_write_data   (hi_data),
    .register_lo_write_enable (lo_we),
    .register_lo_write_data   (lo_data)
  );

  // Clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_write(input logic hwe, input logic [31:0] hd,
                              input logic lwe, input logic [31:0] ld, input int due);
    exp_q.push_back({hwe, hd, lwe, ld});
    due_q.push_back(due);
  endtask

  // Scoreboard: every write pulse must match the head of the expected queue.
  always @(negedge clock) begin
    logic [65:0] e;
    int d;
    if (hi_we || lo_we) begin
      check("write_expected", 66'(exp_q.size() != 0), 66'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("write_cycle", 66'(cyc), 66'(d));
        check("write_value", {hi_we, hi_data, lo_we, lo_data}, e);
      end
    end
  end

  // Reference models
  function automatic logic [63:0] mult_model(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb;
    if (op == OP_MULTU) return {32'd0, a} * {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] div_model(input logic [2:0] op, input logic [31:0] a, b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIVU) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drivers: called right after a posedge; return one cycle later.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, b,
                       input logic an, input logic exp_stall);
    op_valid = 1'b1; op_code = op; operand_a = a; operand_b = b; annul = an;
    @(negedge clock);
    check("stall_at_issue", 66'(stall_request), 66'(exp_stall));
    @(posedge clock); #1;
    op_valid = 1'b0; op_code = OP_NOP; operand_a = 32'd0; operand_b = 32'd0; annul = 1'b0;
  endtask

  task automatic div_op(input logic [2:0] op, input logic [31:0] a, b,
                        input logic [63:0] exp_hl, input int abort_cyc, input logic abort_reset);
    logic [31:0] mthi_val;
    if (abort_cyc == 0) expect_write(1'b1, exp_hl[63:32], 1'b1, exp_hl[31:0], cyc + 33);
    drive(op, a, b, 1'b0, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      if (k == 5) begin
        op_valid = 1'b1; op_code = OP_MULT; operand_a = 32'd3; operand_b = 32'd4;
      end
      if (abort_cyc != 0 && k == abort_cyc) begin
        if (abort_reset) reset = 1'b1;
        else annul = 1'b1;
      end
      @(negedge clock);
      if (abort_cyc == 0 || k <= abort_cyc) begin
        check("div_run_busy", 66'(busy), 66'(1));
        check("div_run_stall", 66'(stall_request), 66'(1));
      end else begin
        check("div_abort_busy", 66'(busy), 66'(0));
        check("div_abort_stall", 66'(stall_request), 66'(0));
      end
      if (abort_reset && abort_cyc != 0 && k == abort_cyc + 1)
        check("reset_clears_outputs", {hi_we, hi_data, lo_we, lo_data}, 66'(0));
      @(posedge clock); #1;
      op_valid = 1'b0; op_code = OP_NOP; operand_a = 32'd0; operand_b = 32'd0;
      annul = 1'b0; reset = 1'b0;
    end
    // Cycle T+33: unit must be free and accept a new op immediately.
    mthi_val = 32'hC0DE_0000 | 32'($urandom_range(0, 65535));
    expect_write(1'b1, mthi_val, 1'b0, lo_data, cyc + 1);
    op_valid = 1'b1; op_code = OP_MTHI; operand_a = mthi_val;
    @(negedge clock);
    check("div_done_busy", 66'(busy), 66'(0));
    check("div_done_stall", 66'(stall_request), 66'(0));
    @(posedge clock); #1;
    op_valid = 1'b0; op_code = OP_NOP; operand_a = 32'd0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [63:0] m;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_stall", 66'(stall_request), 66'(0));
    check("reset_busy", 66'(busy), 66'(0));
    check("reset_outputs", {hi_we, hi_data, lo_we, lo_data}, 66'(0));
    @(posedge clock); #1;

    expect_write(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFF1, cyc + 1);
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    @(negedge clock);
    check("mult_we_t1", 66'({hi_we, lo_we}), 66'(2'b11));
    @(posedge clock); #1;
    @(negedge clock);
    check("mult_we_t2", 66'({hi_we, lo_we}), 66'(2'b00));
    @(posedge clock); #1;

    expect_write(1'b1, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, cyc + 1);
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);

    expect_write(1'b1, 32'hAAAA_5555, 1'b0, 32'hFFFF_FFFE, cyc + 1);
    drive(OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0);
    expect_write(1'b0, 32'hAAAA_5555, 1'b1, 32'h0F0F_0F0F, cyc + 1);
    drive(OP_MTLO, 32'h0F0F_0F0F, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    check("mtlo_stall", 66'(stall_request), 66'(0));
    @(posedge clock); #1;
    @(negedge clock);
    check("data_hold", {hi_data, lo_data}, 66'({32'hAAAA_5555, 32'h0F0F_0F0F}));
    @(posedge clock); #1;

    drive(OP_MULT, 32'd7, 32'd9, 1'b1, 1'b0);
    drive(OP_RSVD, 32'd1, 32'd2, 1'b0, 1'b0);
    drive(OP_DIV, 32'd9, 32'd3, 1'b1, 1'b0);
    @(negedge clock);
    check("annulled_div_busy", 66'(busy), 66'(0));
    @(posedge clock); #1;

    div_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1'b0);
    div_op(OP_DIVU, 32'h1234_5678, 32'd0,        {32'h1234_5678, 32'hFFFF_FFFF}, 0, 1'b0);
    div_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 0, 1'b0);
    div_op(OP_DIV,  32'hFFFF_FFF9, 32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0, 1'b0);
    div_op(OP_DIV,  32'd100,       32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 0, 1'b0);
    div_op(OP_DIVU, 32'd100,       32'd7,        64'd0, 11, 1'b0);
    div_op(OP_DIVU, 32'd100,       32'd7,        64'd0, 11, 1'b1);

    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 30);
      rop = (i % 2 == 0) ? OP_DIV : OP_DIVU;
      div_op(rop, ra, rb, div_model(rop, ra, rb), 0, 1'b0);
      rop = (i % 2 == 0) ? OP_MULT : OP_MULTU;
      ra  = $urandom;
      rb  = $urandom;
      m   = mult_model(rop, ra, rb);
      expect_write(1'b1, m[63:32], 1'b1, m[31:0], cyc + 1);
      drive(rop, ra, rb, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 66'(exp_q.size()), 66'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_controller.md
Name: hilo_mdu_controller

Overview:
Sequences all writes to the HI/LO register pair. Accepts MULT/MULTU, DIV/DIVU, MTHI and MTLO from the execute stage. Runs a 32-iteration restoring divider. Stalls the pipeline while a division is in flight. Emits registered write-enable/data pairs that drive the HI/LO register ports directly.

Parameters:
DIV_CYCLES, 32, number of divider iterations; fixed at 32 for 32-bit operands.

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high; sampled on posedge clock
op_valid  input  1  operation presented this cycle
op_code  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
operand_a  input  32  rs value (multiplicand, dividend, or MTHI/MTLO source)
operand_b  input  32  rt value (multiplier or divisor)
annul  input  1  flush/exception; cancels the pending or in-flight operation
stall_request  output  1  hold upstream pipeline
busy  output  1  divider in DIV_RUN
register_hi_write_enable  output  1  HI write strobe
register_hi_write_data  output  32  HI write value
register_lo_write_enable  output  1  LO write strobe
register_lo_write_data  output  32  LO write value

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE, iteration counter=0.
  - All write enables/data = 0.
  - Divider registers cleared.
  - stall_request and busy are 0 the cycle after reset.
- States: IDLE, DIV_RUN.
- Accept condition: op_valid=1, annul=0, state=IDLE.
  - While in DIV_RUN, op_valid is ignored.
  - annul=1 in IDLE blocks acceptance; no write results.
- Write outputs are registered. Each write enable is a 1-cycle pulse; data holds its last value otherwise.
- MULT accepted at cycle T:
  - 64-bit signed product of a*b.
  - At T+1: HI=product[63:32], LO=product[31:0], both enables high.
- MULTU: same as MULT, but unsigned.
- MTHI at T: at T+1, hi enable=1 and hi data=operand_a; lo enable=0.
- MTLO: mirror of MTHI on the LO side.
- DIV/DIVU accepted at T:
  - stall_request=1 combinationally at T (IDLE with a valid, unannulled div op).
  - Operands latched at T; state→DIV_RUN.
  - DIV_RUN spans T+1..T+32, counter 0..31; one quotient bit per cycle.
  - stall_request=1 and busy=1 throughout DIV_RUN.
  - After the counter=31 cycle: state→IDLE and results are registered.
  - At T+33: LO=quotient, HI=remainder, both enables high, stall_request=0.
  - A new op may be accepted in cycle T+33.
- Signed divide:
  - Divide |a| by |b|.
  - Quotient is negated if sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero, signed or unsigned:
  - Runs the full 32 cycles.
  - Result: LO=0xFFFFFFFF, HI=operand_a.
- annul in DIV_RUN: next state IDLE, no write pulse; stall_request and busy drop the following cycle.
- annul on the same cycle as acceptance of MULT/MTHI/MTLO: op is not accepted (annul wins).
- Reset mid-division: returns to IDLE; no write pulse.
- Simultaneous events: at most one op is accepted per cycle, so HI and LO writes never originate from different ops in the same cycle.
- Reserved op_code 7: accepted as NOP; no write, no stall.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 at T → at T+1 both enables=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1; at T+2 enables=0.
- MULTU a=0xFFFFFFFF, b=2 → at T+1 HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 at T:
  - stall_request=1 for T..T+32; busy=1 for T+1..T+32.
  - At T+33: LO=0xFFFFFFFD, HI=0xFFFFFFFF, stall_request=0.
- DIVU a=0x12345678, b=0 → at T+33 LO=0xFFFFFFFF, HI=0x12345678.
- DIVU 100/7 with annul pulsed at T+11 → IDLE at T+12, no enable ever asserted. Repeat with reset at T+11: same result, outputs 0.
- MTHI 0xAAAA5555 at T, then MTLO 0x0F0F0F0F at T+1:
  - At T+1: hi enable only, data 0xAAAA5555.
  - At T+2: lo enable only, data 0x0F0F0F0F.
  - stall_request stays 0.
